axil_adder_slave: RTL

AXI4-Lite responder fronting a 32-bit two-stage pipelined adder; it is the slave-side endpoint that the master VIP's AXI4LITE_WRITE_BURST/READ_BURST traffic targets in the adder IP block designs. Software writes two operands, triggers a computation through a control register, polls status and reads the result and carry-out. Register accesses use independent AW/W capture, a single outstanding write response and a single outstanding read.

---
 rtl/axil_adder_slave.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axil_adder_slave.sv
// AXI4-Lite register front-end for a 32-bit two-stage pipelined adder.
// Map: 0x0 OPA, 0x4 OPB, 0x8 CTRL/STATUS, 0xC RESULT.
module axil_adder_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    typedef enum logic {RD_IDLE, RD_RESP} rd_st_e;

    rd_st_e      rd_st_q, rd_st_d;
    logic        awready_q, awready_d, wready_q, wready_d;
    logic        arready_q, arready_d;
    logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [1:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [15:0] lo_q, lo_d;
    logic        c16_q, c16_d, ph_q, ph_d;
    logic        busy_q, busy_d, done_q, done_d, cout_q, cout_d;
    logic [31:0] result_q, result_d;

    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, do_wr, ctrl_wr;
    logic [16:0] lo_sum, hi_sum;
    logic [31:0] rd_mux;
    logic        unused;

    assign unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      S_AXI_AWPROT, S_AXI_ARPROT};

    assign aw_hs   = S_AXI_AWVALID && awready_q;
    assign w_hs    = S_AXI_WVALID && wready_q;
    assign ar_hs   = S_AXI_ARVALID && arready_q;
    assign b_hs    = bvalid_q && S_AXI_BREADY;
    assign r_hs    = (rd_st_q == RD_RESP) && S_AXI_RREADY;
    assign do_wr   = aw_got_q && w_got_q;
    assign ctrl_wr = do_wr && (waddr_q == 2'd2) && wstrb_q[0];

    assign lo_sum = {1'b0, a_q[15:0]} + {1'b0, b_q[15:0]};
    assign hi_sum = {1'b0, a_q[31:16]} + {1'b0, b_q[31:16]} + {16'd0, c16_q};

    always_comb begin
        case (S_AXI_ARADDR[3:2])
            2'd0:    rd_mux = opa_q;
            2'd1:    rd_mux = opb_q;
            2'd2:    rd_mux = {29'd0, cout_q, done_q, busy_q};
            default: rd_mux = result_q;
        endcase
    end

    always_comb begin
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        a_d      = a_q;
        b_d      = b_q;
        lo_d     = lo_q;
        c16_d    = c16_q;
        ph_d     = ph_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cout_d   = cout_q;
        result_d = result_q;
        rd_st_d  = rd_st_q;
        rdata_d  = rdata_q;

        if (aw_hs) begin
            aw_got_d = 1'b1;
            waddr_d  = S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
            w_got_d = 1'b1;
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
        end
        if (b_hs)
            bvalid_d = 1'b0;
        if (do_wr) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (waddr_q == 2'd3) ? 2'b10 : 2'b00;
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i] && waddr_q == 2'd0)
                    opa_d[8*i +: 8] = wdata_q[8*i +: 8];
                if (wstrb_q[i] && waddr_q == 2'd1)
                    opb_d[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end

        // Stage 1 then stage 2; busy_q is the pre-edge value for START.
        if (busy_q && !ph_q) begin
            lo_d  = lo_sum[15:0];
            c16_d = lo_sum[16];
            ph_d  = 1'b1;
        end
        if (busy_q && ph_q) begin
            result_d = {hi_sum[15:0], lo_q};
            cout_d   = hi_sum[16];
            busy_d   = 1'b0;
            ph_d     = 1'b0;
            done_d   = 1'b1;
        end
        if (ctrl_wr && wdata_q[0] && !busy_q) begin
            busy_d = 1'b1;
            ph_d   = 1'b0;
            a_d    = opa_q;
            b_d    = opb_q;
        end
        if (ctrl_wr && wdata_q[1])
            done_d = 1'b0;

        if (ar_hs) begin
            rd_st_d = RD_RESP;
            rdata_d = rd_mux;
        end else if (r_hs) begin
            rd_st_d = RD_IDLE;
        end
    end

    assign awready_d = !aw_got_d && !bvalid_d;
    assign wready_d  = !w_got_d && !bvalid_d;
    assign arready_d = (rd_st_d == RD_IDLE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_st_q   <= RD_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            waddr_q   <= 2'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
            rdata_q   <= 32'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            lo_q      <= 16'd0;
            c16_q     <= 1'b0;
            ph_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            rd_st_q   <= rd_st_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            a_q       <= a_d;
            b_q       <= b_d;
            lo_q      <= lo_d;
            c16_q     <= c16_d;
            ph_q      <= ph_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cout_q    <= cout_d;
            result_q  <= result_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (rd_st_q == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
endmodule
